dout_display: RTL and testbench

Output-side display driver for the CPU. It sits downstream of the CPU's `Dout`/`Dval` pair. It captures each valid data byte and converts it to decimal with a sequential shift-add-3 (double-dabble) engine, or passes it through as hex. The result drives a 4-digit multiplexed common-anode 7-segment display on the board.

---
 rtl/dout_display.sv | 186 ++++++++++++++++++
 tb/tb_dout_display.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dout_display.sv
// Display driver for the CPU output byte: captures Din on Dval, converts to BCD with a
// sequential double-dabble engine (or passes hex through) and scans a 4-digit 7-seg display.
module dout_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Din,
    input  logic       Dval,
    input  logic       Mode,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] Anode,
    output logic       Busy,
    output logic [7:0] Shown
);

    localparam logic [20:0] RcntMax = 21'(REFRESH_DIV - 1);
    localparam logic [6:0]  SegBlank = 7'b1111111;
    localparam logic [6:0]  SegH     = 7'b0001001;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e      state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        cap_mode_q, cap_mode_d;
    logic [7:0]  cap_q, cap_d;
    logic        busy_q, busy_d;
    logic [7:0]  shown_q, shown_d;
    logic [3:0]  dig2_q, dig2_d, dig1_q, dig1_d, dig0_q, dig0_d;
    logic        disp_mode_q, disp_mode_d;
    logic [20:0] rcnt_q, rcnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  anode_q, anode_d;
    logic [19:0] sr_adj;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign sr_adj = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8]), sr_q[7:0]};

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        cap_mode_d  = cap_mode_q;
        cap_d       = cap_q;
        busy_d      = busy_q;
        shown_d     = shown_q;
        dig2_d      = dig2_q;
        dig1_d      = dig1_q;
        dig0_d      = dig0_q;
        disp_mode_d = disp_mode_q;
        unique case (state_q)
            StIdle: begin
                if (Dval) begin
                    sr_d       = {12'b0, Din};
                    cap_mode_d = Mode;
                    cap_d      = Din;
                    bitcnt_d   = 3'd0;
                    busy_d     = 1'b1;
                    state_d    = StConv;
                end
            end
            StConv: begin
                sr_d     = {sr_adj[18:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (cap_mode_q) begin
                    dig2_d = 4'd0;
                    dig1_d = cap_q[7:4];
                    dig0_d = cap_q[3:0];
                end else begin
                    dig2_d = sr_q[19:16];
                    dig1_d = sr_q[15:12];
                    dig0_d = sr_q[11:8];
                end
                shown_d     = cap_q;
                disp_mode_d = cap_mode_q;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rcnt_d = rcnt_q + 21'd1;
        sel_d  = sel_q;
        if (rcnt_q == RcntMax) begin
            rcnt_d = 21'd0;
            sel_d  = sel_q + 2'd1;
        end
        anode_d = ~(4'b0001 << sel_q);
        seg_d   = SegBlank;
        if (disp_mode_q) begin
            unique case (sel_q)
                2'd3: seg_d = SegH;
                2'd2: seg_d = SegBlank;
                2'd1: seg_d = seg7(dig1_q);
                default: seg_d = seg7(dig0_q);
            endcase
        end else begin
            // Leading-zero blanking; the ones digit is always lit.
            unique case (sel_q)
                2'd3: seg_d = SegBlank;
                2'd2: seg_d = (dig2_q == 4'd0) ? SegBlank : seg7(dig2_q);
                2'd1: seg_d = (dig2_q == 4'd0 && dig1_q == 4'd0) ? SegBlank : seg7(dig1_q);
                default: seg_d = seg7(dig0_q);
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            sr_q        <= 20'd0;
            bitcnt_q    <= 3'd0;
            cap_mode_q  <= 1'b0;
            cap_q       <= 8'd0;
            busy_q      <= 1'b0;
            shown_q     <= 8'd0;
            dig2_q      <= 4'd0;
            dig1_q      <= 4'd0;
            dig0_q      <= 4'd0;
            disp_mode_q <= 1'b0;
            rcnt_q      <= 21'd0;
            sel_q       <= 2'd0;
            seg_q       <= SegBlank;
            anode_q     <= 4'b1111;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            cap_mode_q  <= cap_mode_d;
            cap_q       <= cap_d;
            busy_q      <= busy_d;
            shown_q     <= shown_d;
            dig2_q      <= dig2_d;
            dig1_q      <= dig1_d;
            dig0_q      <= dig0_d;
            disp_mode_q <= disp_mode_d;
            rcnt_q      <= rcnt_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
            anode_q     <= anode_d;
        end
    end

    assign Seg   = seg_q;
    assign Anode = anode_q;
    assign Busy  = busy_q;
    assign Shown = shown_q;
    assign Dp    = 1'b1;

endmodule

// File: tb/tb_dout_display.sv
// Randomized self-checking bench for dout_display against an arithmetic display model.
module tb_dout_display;

    logic       Clock;
    logic       Reset;
    logic [7:0] Din;
    logic       Dval;
    logic       Mode;
    logic [6:0] Seg;
    logic       Dp;
    logic [3:0] Anode;
    logic       Busy;
    logic [7:0] Shown;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Model of what the display should be showing.
    int exp_val  = 0;
    bit exp_mode = 1'b0;

    dout_display #(.REFRESH_DIV(4)) u_dut (
        .Clock (Clock),
        .Reset (Reset),
        .Din   (Din),
        .Dval  (Dval),
        .Mode  (Mode),
        .Seg   (Seg),
        .Dp    (Dp),
        .Anode (Anode),
        .Busy  (Busy),
        .Shown (Shown)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input bit mode, input int pos);
        int h, t, o;
        if (mode) begin
            if (pos == 3) return 7'b0001001;
            if (pos == 2) return 7'b1111111;
            if (pos == 1) return seg_of(val / 16);
            return seg_of(val % 16);
        end
        h = val / 100;
        t = (val / 10) % 10;
        o = val % 10;
        if (pos == 3) return 7'b1111111;
        if (pos == 2) return (h == 0) ? 7'b1111111 : seg_of(h);
        if (pos == 1) return (h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
        return seg_of(o);
    endfunction

    // Align to the start of digit-0's slot, then check one full 16-cycle scan.
    task automatic scan(input string tag);
        logic [3:0] prev;
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = Anode;
            step();
            if (prev == 4'b0111 && Anode == 4'b1110) found = 1'b1;
        end
        check({tag, "_align"}, {31'd0, found}, 32'd1);
        if (!found) return;
        for (int k = 0; k < 16; k++) begin
            check({tag, "_anode"}, {28'd0, Anode}, {28'd0, ~(4'b0001 << (k / 4))});
            check({tag, "_seg"}, {25'd0, Seg}, {25'd0, exp_seg(exp_val, exp_mode, k / 4)});
            step();
        end
    endtask

    task automatic capture(input int val, input bit mode, input string tag);
        Din  = 8'(val);
        Mode = mode;
        Dval = 1'b1;
        step();
        Dval = 1'b0;
        Din  = 8'($urandom_range(0, 255));
        Mode = 1'($urandom_range(0, 1));
        check({tag, "_busy_T"}, {31'd0, Busy}, 32'd1);
        for (int i = 0; i < 8; i++) step();
        check({tag, "_busy_T8"}, {31'd0, Busy}, 32'd1);
        step();
        check({tag, "_busy_T9"}, {31'd0, Busy}, 32'd0);
        check({tag, "_shown"}, {24'd0, Shown}, val);
        exp_val  = val;
        exp_mode = mode;
        scan(tag);
    endtask

    initial begin
        Reset = 1'b1;
        Din   = 8'd0;
        Dval  = 1'b0;
        Mode  = 1'b0;
        #1;
        check("rst_anode", {28'd0, Anode}, 32'hF);
        check("rst_seg", {25'd0, Seg}, 32'h7F);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_shown", {24'd0, Shown}, 32'd0);
        check("rst_dp", {31'd0, Dp}, 32'd1);
        #11;
        Reset = 1'b0;
        step();
        check("first_anode", {28'd0, Anode}, 32'hE);
        check("first_seg", {25'd0, Seg}, 32'h40);
        scan("zero");

        capture(255, 1'b0, "d255");
        capture(7, 1'b0, "d7");
        capture(100, 1'b0, "d100");
        capture(8'hA5, 1'b1, "hA5");
        capture(10, 1'b0, "d10");
        for (int r = 0; r < 8; r++) begin
            capture(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rnd");
        end

        // Dval/Din activity during conversion is ignored; held Dval recaptures at T+10.
        Mode = 1'b0;
        Din  = 8'd42;
        Dval = 1'b1;
        step();
        Dval = 1'b0;
        step();
        step();
        Din  = 8'd99;
        Dval = 1'b1;
        step();
        Dval = 1'b0;
        step();
        Dval = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("ign_shown42", {24'd0, Shown}, 32'd42);
        check("ign_busy_T9", {31'd0, Busy}, 32'd0);
        step();
        check("ign_busy_T10", {31'd0, Busy}, 32'd1);
        for (int i = 0; i < 9; i++) step();
        Dval = 1'b0;
        check("ign_shown99", {24'd0, Shown}, 32'd99);
        check("ign_busy_T19", {31'd0, Busy}, 32'd0);
        exp_val  = 99;
        exp_mode = 1'b0;
        scan("d99");

        // Reset mid-conversion aborts without commit.
        Din  = 8'd200;
        Dval = 1'b1;
        step();
        Dval = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2;
        Reset = 1'b1;
        #1;
        check("abort_anode", {28'd0, Anode}, 32'hF);
        check("abort_seg", {25'd0, Seg}, 32'h7F);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_shown", {24'd0, Shown}, 32'd0);
        #2;
        Reset = 1'b0;
        step();
        check("abort_anode1", {28'd0, Anode}, 32'hE);
        check("abort_seg1", {25'd0, Seg}, 32'h40);
        exp_val  = 0;
        exp_mode = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("abort_no_commit", {24'd0, Shown}, 32'd0);
        scan("abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
